// File: rtl/waveform_sequencer.sv
// waveform_sequencer: burst phase generator feeding a sine/cosine lookup.
// A start latches period/cycles, a restoring divider derives the phase
// increment inc = floor(2^24 / (CLK_PER_US*period)), then a 24-bit phase
// accumulator runs until the requested number of wraps or a stop.
// Optional feature macro: WAVEFORM_SEQUENCER_RETUNE_EN (background re-divide
// when period changes mid-run, phase-continuous).
module waveform_sequencer #(
  parameter int CLK_PER_US = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  period,
  input  logic [7:0]  cycles,
  output logic [12:0] p1,
  output logic        phase_valid,
  output logic        busy,
  output logic        wrap,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  cycles_lat;
  logic [11:0] den;
  logic [11:0] rem;
  logic [23:0] quo;
  logic [4:0]  div_cnt;
  logic [23:0] inc;
  logic [23:0] acc;
  logic [7:0]  wrap_cnt;
`ifdef WAVEFORM_SEQUENCER_RETUNE_EN
  logic [7:0]  period_lat;
  logic        bg_busy;
`endif

  // Divider step, accumulator sum and wrap bookkeeping.
  logic [11:0] den_new;
  logic [12:0] rem_shift;
  logic [12:0] rem_diff;
  logic        q_bit;
  logic [11:0] rem_step;
  logic [23:0] quo_step;
  logic        div_last;
  logic [24:0] acc_sum;
  logic        carry;
  logic        final_wrap;
  logic [7:0]  wrap_cnt_inc;
  logic [1:0]  div_unused;

  assign den_new = 12'(CLK_PER_US) * {4'd0, period};

  // One restoring-division step; the dividend 2^24 contributes a 1 only on the first step.
  always_comb begin
    rem_shift = {rem, (div_cnt == 5'd0)};
    rem_diff  = rem_shift - {1'b0, den};
    q_bit     = (rem_shift >= {1'b0, den});
    rem_step  = q_bit ? rem_diff[11:0] : rem_shift[11:0];
    quo_step  = {quo[22:0], q_bit};
    div_last  = (div_cnt == 5'd24);
  end

  // Leading quotient bit is always zero for any legal denominator (>= 2).
  assign div_unused = {quo[23], rem_diff[12]};

  assign acc_sum      = {1'b0, acc} + {1'b0, inc};
  assign carry        = acc_sum[24];
  assign final_wrap   = carry && (cycles_lat != 8'd0) &&
                        ((9'(wrap_cnt) + 9'd1) == {1'b0, cycles_lat});
  assign wrap_cnt_inc = (wrap_cnt == 8'hFF) ? 8'hFF : wrap_cnt + 8'd1;

  // acc is held at zero outside RUN, so p1 reads zero there.
  assign p1 = acc[23:11];

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cycles_lat  <= 8'd0;
      den         <= 12'd0;
      rem         <= 12'd0;
      quo         <= 24'd0;
      div_cnt     <= 5'd0;
      inc         <= 24'd0;
      acc         <= 24'd0;
      wrap_cnt    <= 8'd0;
      phase_valid <= 1'b0;
      busy        <= 1'b0;
      wrap        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef WAVEFORM_SEQUENCER_RETUNE_EN
      period_lat  <= 8'd0;
      bg_busy     <= 1'b0;
`endif
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (period == 8'd0) begin
              err <= 1'b1;
            end else begin
              err        <= 1'b0;
              cycles_lat <= cycles;
              den        <= den_new;
              rem        <= 12'd0;
              quo        <= 24'd0;
              div_cnt    <= 5'd0;
              busy       <= 1'b1;
              state      <= CALC;
`ifdef WAVEFORM_SEQUENCER_RETUNE_EN
              period_lat <= period;
              bg_busy    <= 1'b0;
`endif
            end
          end
        end
        CALC: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem     <= rem_step;
            quo     <= quo_step;
            div_cnt <= div_cnt + 5'd1;
            if (div_last) begin
              inc         <= quo_step;
              acc         <= 24'd0;
              wrap_cnt    <= 8'd0;
              phase_valid <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            // Abort wins even over a coinciding final wrap.
            acc         <= 24'd0;
            phase_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (final_wrap) begin
            acc         <= 24'd0;
            wrap_cnt    <= wrap_cnt_inc;
            phase_valid <= 1'b0;
            busy        <= 1'b0;
            wrap        <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            acc  <= acc_sum[23:0];
            wrap <= carry;
            if (carry) begin
              wrap_cnt <= wrap_cnt_inc;
            end
`ifdef WAVEFORM_SEQUENCER_RETUNE_EN
            // Background re-divide: acc keeps using the old inc until the result lands.
            if (period != period_lat) begin
              if (period == 8'd0) begin
                err     <= 1'b1;
                bg_busy <= 1'b0;
              end else begin
                period_lat <= period;
                den        <= den_new;
                rem        <= 12'd0;
                quo        <= 24'd0;
                div_cnt    <= 5'd0;
                bg_busy    <= 1'b1;
              end
            end else if (bg_busy) begin
              rem     <= rem_step;
              quo     <= quo_step;
              div_cnt <= div_cnt + 5'd1;
              if (div_last) begin
                inc     <= quo_step;
                bg_busy <= 1'b0;
              end
            end
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/waveform_sequencer.md
WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 10, meaning clock cycles per microsecond.
REQ-002 SHALL have port clock, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin a burst; sampled in IDLE only.
REQ-005 SHALL have port stop, input, 1 bit: abort the burst.
REQ-006 SHALL have port period, input, 8 bits: waveform period in microseconds, valid range 1..255.
REQ-007 SHALL have port cycles, input, 8 bits: waveform cycles per burst; 0 means continuous.
REQ-008 SHALL have port p1, output, 13 bits: phase index to the sine/cosine lookup.
REQ-009 SHALL have port phase_valid, output, 1 bit: p1 is live.
REQ-010 SHALL have port busy, output, 1 bit: high in CALC or RUN.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on phase wrap.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on burst completion.
REQ-013 SHALL have port err, output, 1 bit: sticky flag for a start with period=0.

Function
REQ-014 SHALL implement a state machine with states IDLE, CALC, RUN and DONE.
REQ-015 In IDLE with start=1, period!=0 and stop=0, SHALL latch period and cycles and enter CALC.
REQ-016 On start with period=0, SHALL set err, stay in IDLE, and clear err on the next valid start.
REQ-017 In CALC, SHALL compute inc = floor(2^24 / (CLK_PER_US*period)) with a sequential restoring divider; CALC lasts exactly 25 cycles, then RUN.
REQ-018 The denominator SHALL be 12 bits wide and inc and the accumulator acc SHALL each be 24 bits wide.
REQ-019 On RUN entry, SHALL set acc=0; in every RUN cycle, SHALL set acc <= acc+inc mod 2^24; p1 SHALL equal acc[23:11].
REQ-020 phase_valid SHALL be high exactly when in RUN.
REQ-021 On a carry out of acc+inc, SHALL register wrap=1 in the cycle the wrapped p1 appears and increment an 8-bit wrap count.
REQ-022 When cycles!=0 and the wrap count reaches cycles, SHALL go to DONE on that same edge, with p1=0 and phase_valid=0.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 With cycles=0, SHALL stay in RUN until stop, and the wrap count SHALL saturate.
REQ-025 stop=1 in CALC or RUN SHALL go to IDLE on the next edge, with p1=0 and no done pulse.
REQ-026 stop arriving with the final wrap SHALL win, with no done pulse.
REQ-027 start and stop together in IDLE SHALL leave the block in IDLE.
REQ-028 start during CALC, RUN or DONE SHALL be ignored.
REQ-029 Without RETUNE_EN, a change on period after latching SHALL be ignored until the next start.

Reset
REQ-030 While reset=0 at a clock edge, SHALL force state=IDLE and p1=0, with phase_valid, busy, wrap, done and err all 0.
REQ-031 While reset=0 at a clock edge, SHALL also clear acc, inc, the wrap count and the divider.
REQ-032 Reset mid-CALC or mid-RUN SHALL abort with no done pulse.

Configuration
REQ-033 Macro WAVEFORM_SEQUENCER_RETUNE_EN: when defined, a period value that differs from the latched value during RUN SHALL start a background 25-cycle divide.
REQ-034 When WAVEFORM_SEQUENCER_RETUNE_EN is defined, acc SHALL keep stepping with the old inc during the divide, and the new inc SHALL apply on the edge after the divide completes, with phase continuous and no acc reset.
REQ-035 When WAVEFORM_SEQUENCER_RETUNE_EN is defined and period changes again during the background divide, SHALL restart the divide.
REQ-036 When WAVEFORM_SEQUENCER_RETUNE_EN is defined and the new period is 0, SHALL set err and keep the old inc.
REQ-037 When WAVEFORM_SEQUENCER_RETUNE_EN is undefined, the background divider SHALL be absent and REQ-029 SHALL hold.

Verification
REQ-038 Test: period=8, cycles=0, start pulse -> busy=1 next cycle; 25 CALC cycles; RUN cycle 1 p1=0, cycle 2 p1=102 (inc=209715); first wrap visible RUN cycle 82.
REQ-039 Test: period=8, cycles=2 -> second wrap on increment 161, then DONE with done=1 for one cycle, then IDLE with p1=0.
REQ-040 Test: period=13 -> inc=129055; RUN cycle 2 p1=63; continuous until stop; stop -> IDLE next edge, no done.
REQ-041 Test: period=0, start -> err=1, stays IDLE; then period=8, start -> err=0, CALC entered.
REQ-042 Test: reset=0 asserted on RUN cycle 40 -> all outputs 0 on next edge; start during RUN ignored; start+stop in IDLE stays IDLE.
REQ-043 Test (WAVEFORM_SEQUENCER_RETUNE_EN only): period 8->13 mid-RUN -> p1 continues with step 102 for 25 cycles, then step 63, with no phase discontinuity.
